// File: rtl/ring_nic_pkg.sv
// ring_nic shared types: flit layout and header field offsets.
// Header lives in the low 16 bits of the 144-bit control word.
package ring_nic_pkg;

  localparam int FLIT_W    = 144;
  localparam int DEST_LSB  = 0;
  localparam int SRC_LSB   = 4;
  localparam int SEQ_LSB   = 8;
  localparam int VALID_BIT = 11;
  localparam int MSHR_LSB  = 12;

  typedef struct packed {
    logic [127:0] payload;
    logic [3:0]   mshr;
    logic         valid;
    logic [2:0]   seq;
    logic [3:0]   src;
    logic [3:0]   dest;
  } flit_t;

  // Stamp an outgoing flit with our address and sequence number.
  function automatic logic [FLIT_W-1:0] set_hdr(
    input logic [FLIT_W-1:0] f,
    input logic [3:0]        src,
    input logic [2:0]        seq
  );
    flit_t t;
    t       = flit_t'(f);
    t.src   = src;
    t.seq   = seq;
    t.valid = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/ring_nic_flit_fifo.sv
// flit_fifo: power-of-two circular flit buffer.
// A push into a full FIFO is taken only if a pop frees a slot this cycle.
module flit_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign count = r_cnt;
  assign head  = r_mem[r_rp];
  assign w_rd  = pop && !empty;
  assign w_wr  = push && (!full || w_rd);

  // Storage array; contents only matter behind a valid count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= din;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
  end

endmodule

// File: rtl/ring_nic.sv
// ring_nic: node interface to a bufferless ring router.
// Injection queue with header stamping; ejection queue with backpressure.
module ring_nic
  import ring_nic_pkg::*;
#(
  parameter logic [3:0] NODE_ID   = 4'd0,
  parameter int         INJ_DEPTH = 4,
  parameter int         EJ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] tx_flit,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [FLIT_W-1:0] inj,
  input  logic              accept,
  input  logic [FLIT_W-1:0] eject,
  input  logic              push,
  output logic              bfull,
  output logic [FLIT_W-1:0] rx_flit,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [1:0]        err
);

  localparam int ICW = $clog2(INJ_DEPTH) + 1;
  localparam int ECW = $clog2(EJ_DEPTH) + 1;

  logic [2:0]        r_seq;
  logic              r_bfull;
  logic [1:0]        r_err;

  logic              w_inj_full;
  logic              w_inj_empty;
  logic [ICW-1:0]    w_inj_cnt;
  logic [FLIT_W-1:0] w_inj_head;
  logic [FLIT_W-1:0] w_inj_din;
  logic              w_enq;
  logic              w_deq;

  logic              w_ej_full;
  logic              w_ej_empty;
  logic [ECW-1:0]    w_ej_cnt;
  logic [FLIT_W-1:0] w_ej_head;
  logic              w_ej_pop;
  logic              w_ej_wr;
  logic              w_ej_ovf;
  logic              w_ej_mis;
  logic [ECW-1:0]    w_ej_next;

  assign tx_ready  = (w_inj_cnt < ICW'(INJ_DEPTH));
  assign w_enq     = tx_valid && !w_inj_full;
  assign w_deq     = accept && !w_inj_empty;
  assign w_inj_din = set_hdr(tx_flit, NODE_ID, r_seq);
  assign inj       = w_inj_empty ? '0 : w_inj_head;

  assign w_ej_pop  = rx_ready && !w_ej_empty;
  assign w_ej_wr   = push && (!w_ej_full || w_ej_pop);
  assign w_ej_ovf  = push && w_ej_full && !w_ej_pop;
  assign w_ej_mis  = push && (eject[DEST_LSB +: 4] != NODE_ID);
  assign w_ej_next = w_ej_cnt + ECW'(w_ej_wr) - ECW'(w_ej_pop);

  assign rx_valid  = !w_ej_empty;
  assign rx_flit   = w_ej_empty ? '0 : w_ej_head;
  assign bfull     = r_bfull;
  assign err       = r_err;

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (INJ_DEPTH)
  ) u_inj_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_enq),
    .pop   (w_deq),
    .din   (w_inj_din),
    .full  (w_inj_full),
    .empty (w_inj_empty),
    .count (w_inj_cnt),
    .head  (w_inj_head)
  );

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (EJ_DEPTH)
  ) u_ej_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_ej_wr),
    .pop   (w_ej_pop),
    .din   (eject),
    .full  (w_ej_full),
    .empty (w_ej_empty),
    .count (w_ej_cnt),
    .head  (w_ej_head)
  );

  // Sequence number advances once per accepted agent flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_seq <= '0;
    else if (w_enq) r_seq <= r_seq + 3'd1;
  end

  // Raise backpressure one slot early so an in-flight push still fits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bfull <= 1'b0;
    else r_bfull <= (w_ej_next >= ECW'(EJ_DEPTH - 1));
  end

  // Sticky overflow and misroute flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      if (w_ej_ovf) r_err[0] <= 1'b1;
      if (w_ej_mis) r_err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// tb_ring_nic: directed scenarios plus a randomized run
// checked against a queue-based model of the NIC.
module tb_ring_nic;

  localparam logic [3:0] NID = 4'd5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [143:0] tx_flit = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [143:0] inj;
  logic         accept = 1'b0;
  logic [143:0] eject = '0;
  logic         push = 1'b0;
  logic         bfull;
  logic [143:0] rx_flit;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic [1:0]   err;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ring_nic #(
    .NODE_ID   (NID),
    .INJ_DEPTH (4),
    .EJ_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_flit  (tx_flit),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .inj      (inj),
    .accept   (accept),
    .eject    (eject),
    .push     (push),
    .bfull    (bfull),
    .rx_flit  (rx_flit),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .err      (err)
  );

  function automatic logic [143:0] rw(input logic [143:0] f,
                                      input logic [2:0] s);
    logic [143:0] r;
    r = f;
    r[7:4] = NID;
    r[10:8] = s;
    r[11] = 1'b1;
    return r;
  endfunction

  function automatic logic [143:0] rnd_flit(input logic [3:0] d);
    logic [143:0] f;
    f = {$urandom(), $urandom(), $urandom(), $urandom(),
         16'($urandom())};
    f[3:0] = d;
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tx_valid = 1'b0;
    accept = 1'b0;
    push = 1'b0;
    rx_ready = 1'b0;
    tx_flit = '0;
    eject = '0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (tx_ready !== 1'b1 || inj !== '0 || bfull !== 1'b0) begin
      errs++;
      $display("FAIL reset_inj: tx_ready=%b inj=%h bfull=%b want 1/0/0",
               tx_ready, inj, bfull);
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_flit !== '0 || err !== 2'b00) begin
      errs++;
      $display("FAIL reset_ej: rx_valid=%b rx_flit=%h err=%b want 0/0/00",
               rx_valid, rx_flit, err);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: tx_ready=%b rx_valid=%b want 1/0",
               tx_ready, rx_valid);
    end
  endtask

  task automatic test_inject_hold;
    logic [143:0] f;
    logic [143:0] e;
    do_reset();
    f = rnd_flit(4'd7);
    f[31:0] = 32'h0011_1007;
    e = f;
    e[15:0] = 16'h1857;
    tx_flit = f;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (inj[15:0] !== 16'h1857) begin
      errs++;
      $display("FAIL inj_hdr: got %h want 1857", inj[15:0]);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (inj !== e) begin
        errs++;
        $display("FAIL inj_hold%0d: got %h want %h", k, inj, e);
      end
    end
    accept = 1'b1;
    tick();
    accept = 1'b0;
    checks++;
    if (inj !== '0) begin
      errs++;
      $display("FAIL inj_pop: got %h want 0", inj);
    end
  endtask

  task automatic test_inj_full;
    logic [143:0] f [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      f[i] = rnd_flit(4'(i));
      tx_flit = f[i];
      tx_valid = 1'b1;
      tick();
      checks++;
      if (tx_ready !== (i < 3)) begin
        errs++;
        $display("FAIL tx_ready%0d: got %b want %b", i, tx_ready, i < 3);
      end
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (inj !== rw(f[i], 3'(i))) begin
        errs++;
        $display("FAIL inj_order%0d: got %h want %h",
                 i, inj, rw(f[i], 3'(i)));
      end
      accept = 1'b1;
      tick();
    end
    accept = 1'b0;
    checks++;
    if (inj !== '0 || tx_ready !== 1'b1) begin
      errs++;
      $display("FAIL inj_drained: inj=%h tx_ready=%b want 0/1",
               inj, tx_ready);
    end
    accept = 1'b1;
    tick();
    accept = 1'b0;
    checks++;
    if (inj !== '0 || tx_ready !== 1'b1) begin
      errs++;
      $display("FAIL inj_underflow: inj=%h tx_ready=%b want 0/1",
               inj, tx_ready);
    end
  endtask

  task automatic test_seq_wrap;
    logic [143:0] f;
    do_reset();
    accept = 1'b1;
    for (int k = 0; k < 9; k++) begin
      f = rnd_flit(4'd2);
      tx_flit = f;
      tx_valid = 1'b1;
      tick();
      checks++;
      if (inj !== rw(f, 3'(k))) begin
        errs++;
        $display("FAIL seq%0d: got %h want %h", k, inj, rw(f, 3'(k)));
      end
    end
    checks++;
    if (inj[10:8] !== 3'd0) begin
      errs++;
      $display("FAIL seq_wrap: got %0d want 0", inj[10:8]);
    end
    tx_valid = 1'b0;
    tick();
    accept = 1'b0;
    checks++;
    if (inj !== '0) begin
      errs++;
      $display("FAIL seq_end: got %h want 0", inj);
    end
  endtask

  task automatic test_eject_fill;
    logic [143:0] e [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e[i] = rnd_flit(NID);
      eject = e[i];
      push = 1'b1;
      tick();
      checks++;
      if (bfull !== (i >= 2) || err !== ((i == 4) ? 2'b01 : 2'b00)) begin
        errs++;
        $display("FAIL ej_fill%0d: bfull=%b err=%b want %b/%b", i,
                 bfull, err, i >= 2, (i == 4) ? 2'b01 : 2'b00);
      end
    end
    push = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_flit !== e[i]) begin
        errs++;
        $display("FAIL ej_drain%0d: v=%b got %h want %h",
                 i, rx_valid, rx_flit, e[i]);
      end
      tick();
    end
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || bfull !== 1'b0 || err !== 2'b01) begin
      errs++;
      $display("FAIL ej_empty: v=%b bfull=%b err=%b want 0/0/01",
               rx_valid, bfull, err);
    end
  endtask

  task automatic test_eject_simul;
    logic [143:0] e [5];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e[i] = rnd_flit(NID);
      eject = e[i];
      push = 1'b1;
      tick();
    end
    e[4] = rnd_flit(NID);
    eject = e[4];
    rx_ready = 1'b1;
    tick();
    push = 1'b0;
    rx_ready = 1'b0;
    checks++;
    if (err !== 2'b00 || bfull !== 1'b1) begin
      errs++;
      $display("FAIL simul: err=%b bfull=%b want 00/1", err, bfull);
    end
    rx_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_flit !== e[i]) begin
        errs++;
        $display("FAIL simul_drain%0d: v=%b got %h want %h",
                 i, rx_valid, rx_flit, e[i]);
      end
      tick();
    end
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errs++;
      $display("FAIL simul_count: rx_valid=%b want 0", rx_valid);
    end
  endtask

  task automatic test_misroute;
    logic [143:0] f;
    do_reset();
    f = rnd_flit(4'd3);
    eject = f;
    push = 1'b1;
    tick();
    push = 1'b0;
    checks++;
    if (rx_valid !== 1'b1 || rx_flit !== f || err !== 2'b10) begin
      errs++;
      $display("FAIL misroute: v=%b flit=%h err=%b want 1/%h/10",
               rx_valid, rx_flit, err, f);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx_flit = rnd_flit(4'd1);
      tx_valid = 1'b1;
      eject = rnd_flit(NID);
      push = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    push = 1'b0;
    checks++;
    if (inj === '0 || rx_valid !== 1'b1 || bfull !== 1'b1) begin
      errs++;
      $display("FAIL arst_pre: inj=%h v=%b bfull=%b want nz/1/1",
               inj, rx_valid, bfull);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (inj !== '0 || rx_valid !== 1'b0 || bfull !== 1'b0 ||
        tx_ready !== 1'b1) begin
      errs++;
      $display("FAIL arst: inj=%h v=%b bfull=%b rdy=%b want 0/0/0/1",
               inj, rx_valid, bfull, tx_ready);
    end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_random;
    logic [143:0] mi[$];
    logic [143:0] me[$];
    logic [2:0]   ms;
    logic [1:0]   merr;
    logic         mbf;
    logic [143:0] tf;
    logic [143:0] ef;
    logic         tv, ac, pu, rr, en;
    int           nerr;
    do_reset();
    ms = 3'd0;
    merr = 2'b00;
    mbf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      nerr = errs;
      checks++;
      if (tx_ready !== (mi.size() < 4)) errs++;
      checks++;
      if (inj !== ((mi.size() > 0) ? mi[0] : 144'h0)) errs++;
      checks++;
      if (rx_valid !== (me.size() > 0)) errs++;
      if (me.size() > 0) begin
        checks++;
        if (rx_flit !== me[0]) errs++;
      end
      checks++;
      if (bfull !== mbf || err !== merr) errs++;
      if (errs != nerr && errs < 20)
        $display("FAIL rand%0d: rdy=%b inj=%h v=%b rx=%h bf=%b err=%b exp_inj=%0d exp_ej=%0d exp_bf=%b exp_err=%b",
                 n, tx_ready, inj[15:0], rx_valid, rx_flit[15:0], bfull,
                 err, mi.size(), me.size(), mbf, merr);
      tv = ($urandom_range(0, 2) != 0);
      ac = ($urandom_range(0, 2) == 0);
      pu = ($urandom_range(0, 1) != 0);
      rr = ($urandom_range(0, 2) == 0);
      tf = rnd_flit(4'($urandom_range(0, 15)));
      ef = rnd_flit(($urandom_range(0, 5) == 0) ?
                    4'($urandom_range(0, 15)) : NID);
      tx_flit = tf;
      tx_valid = tv;
      accept = ac;
      eject = ef;
      push = pu;
      rx_ready = rr;
      tick();
      en = tv && (mi.size() < 4);
      if (ac && mi.size() > 0) void'(mi.pop_front());
      if (en) begin
        mi.push_back(rw(tf, ms));
        ms = ms + 3'd1;
      end
      if (rr && me.size() > 0) void'(me.pop_front());
      if (pu) begin
        if (me.size() >= 4) merr[0] = 1'b1;
        else me.push_back(ef);
        if (ef[3:0] != NID) merr[1] = 1'b1;
      end
      mbf = (me.size() >= 3);
    end
    tx_valid = 1'b0;
    accept = 1'b0;
    push = 1'b0;
    rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inject_hold();
    test_inj_full();
    test_seq_wrap();
    test_eject_fill();
    test_eject_simul();
    test_misroute();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
